// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low row strobe, debounces the column returns, emits one hex code per press.
// Latency: (DEBOUNCE_SCANS-1) scan frames from first hit to key_valid, plus one registered cycle.
// Backpressure: key_code is held while key_valid=1; a press accepted while still unconsumed sets sticky overrun and is dropped.
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       fpga_clk,
    input  logic       rst,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_down,
    output logic       overrun
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } state_t;

    logic [DIV_W-1:0] div;
    logic             ce;
    logic [3:0]       col_m;
    logic [3:0]       col_s;
    logic [1:0]       row_idx;

    logic             hit;
    logic [1:0]       hit_col;

    state_t           state, state_n;
    logic [1:0]       key_row, key_row_n;
    logic [1:0]       key_col, key_col_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] rcnt, rcnt_n;
    logic             accept;
    logic [3:0]       accept_code;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'h0;
            4'hD: code = 4'hF;
            4'hE: code = 4'hE;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    assign ce = (div == DIV_LAST);

    // Row strobe and column sampling advance together, so the sample on ce belongs to the row being left.
    always_ff @(posedge fpga_clk) begin
        if (rst) begin
            div     <= '0;
            col_m   <= 4'hF;
            col_s   <= 4'hF;
            row     <= 4'b1110;
            row_idx <= 2'd0;
        end else begin
            col_m <= col;
            col_s <= col_m;
            div   <= ce ? '0 : div + 1'b1;
            if (ce) begin
                row     <= {row[2:0], row[3]};
                row_idx <= row_idx + 2'd1;
            end
        end
    end

    assign hit = ~&col_s;

    always_comb begin
        hit_col = 2'd0;
        casez (col_s)
            4'b???0: hit_col = 2'd0;
            4'b??01: hit_col = 2'd1;
            4'b?011: hit_col = 2'd2;
            4'b0111: hit_col = 2'd3;
            default: hit_col = 2'd0;
        endcase
    end

    always_ff @(posedge fpga_clk) begin
        if (rst) begin
            state   <= IDLE;
            key_row <= 2'd0;
            key_col <= 2'd0;
            cnt     <= '0;
            rcnt    <= '0;
        end else begin
            state   <= state_n;
            key_row <= key_row_n;
            key_col <= key_col_n;
            cnt     <= cnt_n;
            rcnt    <= rcnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        key_row_n = key_row;
        key_col_n = key_col;
        cnt_n     = cnt;
        rcnt_n    = rcnt;
        accept    = 1'b0;
        if (ce) begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        key_row_n = row_idx;
                        key_col_n = hit_col;
                        cnt_n     = CNT_W'(1);
                        state_n   = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    // Once a key is being tracked, other rows are ignored until it is released.
                    if (row_idx == key_row) begin
                        if (hit && (hit_col == key_col)) begin
                            if (cnt == CNT_LAST) begin
                                accept  = 1'b1;
                                rcnt_n  = '0;
                                state_n = PRESSED;
                            end else begin
                                cnt_n = cnt + 1'b1;
                            end
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
                PRESSED: begin
                    if (row_idx == key_row) begin
                        if (col_s[key_col]) begin
                            if (rcnt == CNT_LAST) begin
                                state_n = IDLE;
                            end else begin
                                rcnt_n = rcnt + 1'b1;
                            end
                        end else begin
                            rcnt_n = '0;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign accept_code = key_map(key_row, key_col);
    assign key_down    = (state == PRESSED);

    // An ack landing on the accept edge frees the slot in time for the new code.
    always_ff @(posedge fpga_clk) begin
        if (rst) begin
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (accept) begin
            if (!key_valid || key_ack) begin
                key_code  <= accept_code;
                key_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (key_valid && key_ack) begin
            key_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural keypad matrix driving col from row.
module tb_keypad_scanner;

    logic       fpga_clk = 1'b0;
    logic       rst;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       key_down;
    logic       overrun;

    logic [15:0] keys;
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [1:0] kr;
        logic [1:0] kc;
        logic [3:0] code;
    } vec_t;

    vec_t tbl[16];

    always #5 fpga_clk = ~fpga_clk;
    always @(posedge fpga_clk) cyc <= cyc + 1;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .fpga_clk (fpga_clk),
        .rst      (rst),
        .col      (col),
        .row      (row),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_ack  (key_ack),
        .key_down (key_down),
        .overrun  (overrun)
    );

    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && (row[r] == 1'b0)) col[c] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge fpga_clk);
    endtask

    task automatic wait_row(input logic [3:0] val, input string name);
        int n = 0;
        while (row !== val && n < 100) begin
            tick(1);
            n++;
        end
        if (row !== val) begin
            checks++;
            errors++;
            $display("FAIL %s: row %b never reached %b", name, row, val);
        end
    endtask

    task automatic wait_valid(input logic v, input string name);
        int n = 0;
        while (key_valid !== v && n < 200) begin
            tick(1);
            n++;
        end
        if (key_valid !== v) begin
            checks++;
            errors++;
            $display("FAIL %s: key_valid %b after %0d cycles, expected %b", name, key_valid, n, v);
        end
    endtask

    task automatic wait_down(input logic v, input string name);
        int n = 0;
        while (key_down !== v && n < 200) begin
            tick(1);
            n++;
        end
        if (key_down !== v) begin
            checks++;
            errors++;
            $display("FAIL %s: key_down %b after %0d cycles, expected %b", name, key_down, n, v);
        end
    endtask

    task automatic ack_pulse();
        key_ack = 1'b1;
        tick(1);
        key_ack = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic seen;
        logic [3:0] er;

        tbl = '{
            '{2'd0, 2'd0, 4'h1}, '{2'd0, 2'd1, 4'h2}, '{2'd0, 2'd2, 4'h3}, '{2'd0, 2'd3, 4'hA},
            '{2'd1, 2'd0, 4'h4}, '{2'd1, 2'd1, 4'h5}, '{2'd1, 2'd2, 4'h6}, '{2'd1, 2'd3, 4'hB},
            '{2'd2, 2'd0, 4'h7}, '{2'd2, 2'd1, 4'h8}, '{2'd2, 2'd2, 4'h9}, '{2'd2, 2'd3, 4'hC},
            '{2'd3, 2'd0, 4'h0}, '{2'd3, 2'd1, 4'hF}, '{2'd3, 2'd2, 4'hE}, '{2'd3, 2'd3, 4'hD}
        };

        rst = 1'b1;
        keys = 16'h0;
        key_ack = 1'b0;
        tick(3);
        check("rst_row", row, 4'b1110);
        check("rst_code", key_code, 4'h0);
        check("rst_valid", key_valid, 1'b0);
        check("rst_down", key_down, 1'b0);
        check("rst_overrun", overrun, 1'b0);

        // Idle scan: each row held 4 cycles, rotating 1110 -> 1101 -> 1011 -> 0111.
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 32; k++) begin
            er = ~(4'b0001 << ((k / 4) % 4));
            check($sformatf("idle_row[%0d]", k), row, er);
            seen = seen | key_valid | key_down | overrun;
            tick(1);
        end
        check("idle_flags", seen, 1'b0);

        for (int i = 0; i < 16; i++) begin
            keys[tbl[i].kr*4 + tbl[i].kc] = 1'b1;
            wait_valid(1'b1, $sformatf("tbl_valid[%0d]", i));
            check($sformatf("tbl_code[%0d]", i), key_code, tbl[i].code);
            check($sformatf("tbl_down[%0d]", i), key_down, 1'b1);
            ack_pulse();
            check($sformatf("tbl_ack[%0d]", i), key_valid, 1'b0);
            keys = 16'h0;
            wait_down(1'b0, $sformatf("tbl_release[%0d]", i));
        end
        check("tbl_overrun", overrun, 1'b0);

        // '5': latency from first hit, hold without repeat, release timing.
        wait_row(4'b1110, "k5_sync");
        keys[1*4+1] = 1'b1;
        wait_row(4'b1011, "k5_hit");
        t0 = cyc;
        wait_valid(1'b1, "k5_valid");
        check("k5_latency", cyc - t0, 32);
        check("k5_code", key_code, 4'h5);
        check("k5_down", key_down, 1'b1);
        tick(48);
        check("k5_hold_valid", key_valid, 1'b1);
        check("k5_hold_code", key_code, 4'h5);
        ack_pulse();
        check("k5_ack", key_valid, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 64; k++) begin
            seen = seen | key_valid;
            tick(1);
        end
        check("k5_no_repeat", seen, 1'b0);
        check("k5_still_down", key_down, 1'b1);
        wait_row(4'b1110, "k5_rel_sync");
        keys = 16'h0;
        wait_row(4'b1011, "k5_rel_hit");
        tick(31);
        check("k5_down_before_release", key_down, 1'b1);
        tick(1);
        check("k5_released", key_down, 1'b0);

        // Bounce on '9': low for exactly one row-2 sample.
        wait_row(4'b1101, "bnc_sync");
        wait_row(4'b1011, "bnc_row2");
        keys[2*4+2] = 1'b1;
        wait_row(4'b0111, "bnc_sampled");
        keys = 16'h0;
        seen = 1'b0;
        for (int k = 0; k < 80; k++) begin
            seen = seen | key_valid | key_down;
            tick(1);
        end
        check("bnc_quiet", seen, 1'b0);

        // '1' and '3' together: lowest column wins, one code only.
        keys[0] = 1'b1;
        keys[2] = 1'b1;
        wait_valid(1'b1, "multi_valid");
        check("multi_code", key_code, 4'h1);
        ack_pulse();
        seen = 1'b0;
        for (int k = 0; k < 64; k++) begin
            seen = seen | key_valid;
            tick(1);
        end
        check("multi_single", seen, 1'b0);
        keys = 16'h0;
        wait_down(1'b0, "multi_release");

        // Overrun: 'D' left unconsumed, then '0' accepted and dropped.
        keys[15] = 1'b1;
        wait_valid(1'b1, "ovr_d_valid");
        check("ovr_d_code", key_code, 4'hD);
        keys = 16'h0;
        wait_down(1'b0, "ovr_d_release");
        keys[12] = 1'b1;
        wait_down(1'b1, "ovr_0_down");
        check("ovr_code_kept", key_code, 4'hD);
        check("ovr_valid", key_valid, 1'b1);
        check("ovr_flag", overrun, 1'b1);
        keys = 16'h0;
        wait_down(1'b0, "ovr_0_release");

        // 'E' accepted on the same edge as an ack: slot reloads, overrun stays set.
        wait_row(4'b1110, "ack_sync");
        keys[14] = 1'b1;
        wait_row(4'b0111, "ack_row3");
        wait_row(4'b1110, "ack_hit");
        tick(31);
        check("ack_pre_code", key_code, 4'hD);
        key_ack = 1'b1;
        tick(1);
        key_ack = 1'b0;
        check("ack_same_valid", key_valid, 1'b1);
        check("ack_same_code", key_code, 4'hE);
        check("ack_same_overrun", overrun, 1'b1);
        check("ack_same_down", key_down, 1'b1);
        keys = 16'h0;
        wait_down(1'b0, "ack_release");

        // Reset during DEBOUNCE of '6' while 'E' is still pending.
        wait_row(4'b1110, "rd_sync");
        keys[1*4+2] = 1'b1;
        wait_row(4'b1011, "rd_hit");
        tick(2);
        rst = 1'b1;
        keys = 16'h0;
        tick(1);
        check("rd_row", row, 4'b1110);
        check("rd_valid", key_valid, 1'b0);
        check("rd_code", key_code, 4'h0);
        check("rd_overrun", overrun, 1'b0);
        check("rd_down", key_down, 1'b0);
        rst = 1'b0;
        tick(4);
        check("rd_resume_row", row, 4'b1101);
        seen = 1'b0;
        for (int k = 0; k < 96; k++) begin
            seen = seen | key_valid | key_down;
            tick(1);
        end
        check("rd_no_key", seen, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
